load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/load_store_unit_if.sv | 38 +++
 rtl/lsu_load_align.sv | 36 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: RV32I width codes,
// memory lane/read-enable codes and the FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] LANE_IDLE = 4'b0000;
    localparam logic [3:0] LANE_B0   = 4'b0001;
    localparam logic [3:0] LANE_B1   = 4'b0010;
    localparam logic [3:0] LANE_B2   = 4'b0011;
    localparam logic [3:0] LANE_B3   = 4'b0100;
    localparam logic [3:0] LANE_H0   = 4'b0101;
    localparam logic [3:0] LANE_H2   = 4'b0111;
    localparam logic [3:0] LANE_W    = 4'b1111;

    localparam logic [1:0] RD_IDLE = 2'b00;
    localparam logic [1:0] RD_BYTE = 2'b01;
    localparam logic [1:0] RD_HALF = 2'b10;
    localparam logic [1:0] RD_WORD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_e;

    // Stores only exist in signed-name widths; BU/HU are load-only.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: funct3_legal = 1'b1;
            F3_BU, F3_HU:     funct3_legal = ~we;
            default:          funct3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the request, response and data-memory signals of load_store_unit.
// The requester side (master) also models the data memory.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_enable;
    logic [1:0]  mem_rd_enable;
    logic [31:0] mem_rd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_error;

    modport master (
        output req_valid, req_we, req_funct3, req_base, req_offset, req_wdata, req_rd,
        output resp_ready, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_error,
        input  mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_base, req_offset, req_wdata, req_rd,
        input  resp_ready, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_error,
        output mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable
    );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the byte/halfword addressed by ea_lo out of a read word and
// sign- or zero-extends it according to the RV32I width code.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        byte_v = word[7:0];
        case (ea_lo)
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = ea_lo[1] ? word[31:16] : word[15:0];

        result = word;
        case (funct3)
            F3_B:    result = {{24{byte_v[7]}}, byte_v};
            F3_BU:   result = {24'b0, byte_v};
            F3_H:    result = {{16{half_v[15]}}, half_v};
            F3_HU:   result = {16'b0, half_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP, faults skip ACCESS.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned half/word accesses instead of forcing alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_base_i,
    input  logic [31:0] req_offset_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wr_data_o,
    output logic [3:0]  mem_wr_enable_o,
    output logic [1:0]  mem_rd_enable_o,
    input  logic [31:0] mem_rd_data_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic [4:0]  resp_rd_o,
    output logic        resp_error_o
);

    state_e      state_q, state_d;
    logic [31:0] ea_q, rdata_q, wdata_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        we_q, err_q;

    logic [31:0] ea_raw, ea_use, load_result;
    logic        misalign, out_of_range, fault;

    assign ea_raw       = req_base_i + req_offset_i;
    assign out_of_range = ea_raw >= 32'(MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_funct3_i[1:0] == 2'b01) && ea_raw[0]) ||
                      ((req_funct3_i[1:0] == 2'b10) && (ea_raw[1:0] != 2'b00));
    assign ea_use   = ea_raw;
`else
    assign misalign = 1'b0;
    assign ea_use   = (req_funct3_i[1:0] == 2'b01) ? {ea_raw[31:1], 1'b0} :
                      (req_funct3_i[1:0] == 2'b10) ? {ea_raw[31:2], 2'b00} : ea_raw;
`endif

    assign fault = ~funct3_legal(req_we_i, req_funct3_i) | out_of_range | misalign;

    lsu_load_align u_load_align (
        .word   (mem_rd_data_i),
        .ea_lo  (ea_q[1:0]),
        .funct3 (funct3_q),
        .result (load_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid_i) state_d = fault ? S_RESP : S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   if (resp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ea_q     <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else if (state_q == S_IDLE && req_valid_i) begin
            ea_q     <= ea_use;
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            wdata_q  <= req_wdata_i;
            rd_q     <= req_rd_i;
            err_q    <= fault;
            rdata_q  <= '0;
        end else if (state_q == S_ACCESS) begin
            rdata_q  <= we_q ? 32'b0 : load_result;
        end
    end

    // Memory is strobed only during the single ACCESS cycle.
    always_comb begin
        mem_addr_o      = '0;
        mem_wr_data_o   = '0;
        mem_wr_enable_o = LANE_IDLE;
        mem_rd_enable_o = RD_IDLE;
        if (state_q == S_ACCESS) begin
            mem_addr_o = {2'b00, ea_q[31:2]};
            if (!we_q) begin
                mem_rd_enable_o = RD_WORD;
            end else begin
                case (funct3_q[1:0])
                    2'b00: begin
                        mem_wr_data_o = {24'b0, wdata_q[7:0]};
                        case (ea_q[1:0])
                            2'd0:    mem_wr_enable_o = LANE_B0;
                            2'd1:    mem_wr_enable_o = LANE_B1;
                            2'd2:    mem_wr_enable_o = LANE_B2;
                            default: mem_wr_enable_o = LANE_B3;
                        endcase
                    end
                    2'b01: begin
                        mem_wr_data_o   = {16'b0, wdata_q[15:0]};
                        mem_wr_enable_o = ea_q[1] ? LANE_H2 : LANE_H0;
                    end
                    default: begin
                        mem_wr_data_o   = wdata_q;
                        mem_wr_enable_o = LANE_W;
                    end
                endcase
            end
        end
    end

    // Ready is held low while reset is asserted so every output reads 0.
    assign req_ready_o  = (state_q == S_IDLE) & reset_n_i;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_rd_o    = rd_q;
    assign resp_error_o = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// stall/reset sequences and random traffic against a byte-array reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_BYTES = 256;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [1:0]  ren;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wdata;
        exp_t        e;
        string       name;
    } vec_t;

    logic clock_i   = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clock_i = ~clock_i;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clock_i         (clock_i),
        .reset_n_i       (reset_n_i),
        .req_valid_i     (bus.req_valid),
        .req_ready_o     (bus.req_ready),
        .req_we_i        (bus.req_we),
        .req_funct3_i    (bus.req_funct3),
        .req_base_i      (bus.req_base),
        .req_offset_i    (bus.req_offset),
        .req_wdata_i     (bus.req_wdata),
        .req_rd_i        (bus.req_rd),
        .mem_addr_o      (bus.mem_addr),
        .mem_wr_data_o   (bus.mem_wr_data),
        .mem_wr_enable_o (bus.mem_wr_enable),
        .mem_rd_enable_o (bus.mem_rd_enable),
        .mem_rd_data_i   (bus.mem_rd_data),
        .resp_valid_o    (bus.resp_valid),
        .resp_ready_i    (bus.resp_ready),
        .resp_rdata_o    (bus.resp_rdata),
        .resp_rd_o       (bus.resp_rd),
        .resp_error_o    (bus.resp_error)
    );

    // Data memory seen by the DUT, and the model's independent copy.
    logic [7:0] mem     [MEM_BYTES] = '{default: 8'h00};
    logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};

    assign bus.mem_rd_data = {mem[{bus.mem_addr[5:0], 2'd3}], mem[{bus.mem_addr[5:0], 2'd2}],
                              mem[{bus.mem_addr[5:0], 2'd1}], mem[{bus.mem_addr[5:0], 2'd0}]};

    always @(posedge clock_i) begin
        case (bus.mem_wr_enable)
            4'b0001, 4'b0010, 4'b0011, 4'b0100:
                mem[{bus.mem_addr[5:0], 2'(bus.mem_wr_enable - 4'd1)}] <= bus.mem_wr_data[7:0];
            4'b0101, 4'b0111: begin
                mem[{bus.mem_addr[5:0], bus.mem_wr_enable[1], 1'b0}] <= bus.mem_wr_data[7:0];
                mem[{bus.mem_addr[5:0], bus.mem_wr_enable[1], 1'b1}] <= bus.mem_wr_data[15:8];
            end
            4'b1111: begin
                mem[{bus.mem_addr[5:0], 2'd0}] <= bus.mem_wr_data[7:0];
                mem[{bus.mem_addr[5:0], 2'd1}] <= bus.mem_wr_data[15:8];
                mem[{bus.mem_addr[5:0], 2'd2}] <= bus.mem_wr_data[23:16];
                mem[{bus.mem_addr[5:0], 2'd3}] <= bus.mem_wr_data[31:24];
            end
            default: ;
        endcase
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory, width from funct3, plain arithmetic.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] ea, input logic [31:0] wdata);
        exp_t        e;
        int          size;
        logic        legal;
        logic [31:0] ea_a, v;
        e = '{err: 1'b0, rdata: 32'h0, addr: 32'h0, wen: 4'h0, ren: 2'h0, wdata: 32'h0};
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = (f3 inside {3'd0, 3'd1, 3'd2}) || (!we && (f3 inside {3'd4, 3'd5}));
        e.err = !legal || (ea >= MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
        if (legal && (ea % size) != 0) e.err = 1'b1;
        ea_a = ea;
`else
        ea_a = ea - (ea % size);
`endif
        if (e.err) return e;
        e.addr = ea_a / 4;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[ea_a + i] = wdata[8*i +: 8];
            e.wdata = (size == 4) ? wdata : wdata % (32'd1 << (8 * size));
            e.wen   = (size == 4) ? 4'd15 : (size == 2) ? ((ea_a % 4 == 0) ? 4'd5 : 4'd7)
                                                        : 4'(1 + ea_a % 4);
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (32'(ref_mem[ea_a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v - (32'd1 << (8 * size));
            e.rdata = v;
            e.ren   = 2'd3;
        end
        return e;
    endfunction

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wdata, input logic [4:0] rd,
                       input exp_t e, input string tag, input int stall);
        int          lat, n_strobe;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_wen;
        logic [1:0]  s_ren;
        @(negedge clock_i);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_base = base; bus.req_offset = off; bus.req_wdata = wdata; bus.req_rd = rd;
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clock_i); #1;
        bus.req_valid = 1'b0;
        lat = 0; n_strobe = 0; s_addr = 0; s_wdata = 0; s_wen = 0; s_ren = 0;
        while (!bus.resp_valid && lat < 8) begin
            if (bus.mem_wr_enable != 0 || bus.mem_rd_enable != 0) begin
                n_strobe++;
                s_addr = bus.mem_addr; s_wdata = bus.mem_wr_data;
                s_wen = bus.mem_wr_enable; s_ren = bus.mem_rd_enable;
            end
            @(posedge clock_i); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), e.err ? 32'd0 : 32'd1);
        check({tag, " strobes"}, 32'(n_strobe), e.err ? 32'd0 : 32'd1);
        check({tag, " resp_strobe"}, 32'({bus.mem_wr_enable, bus.mem_rd_enable}), 32'd0);
        check({tag, " mem_addr"}, s_addr, e.addr);
        check({tag, " wr_enable"}, 32'(s_wen), 32'(e.wen));
        check({tag, " rd_enable"}, 32'(s_ren), 32'(e.ren));
        check({tag, " wr_data"}, s_wdata, e.wdata);
        check({tag, " error"}, 32'(bus.resp_error), 32'(e.err));
        check({tag, " rdata"}, bus.resp_rdata, e.rdata);
        check({tag, " rd"}, 32'(bus.resp_rd), 32'(rd));
        for (int s = 0; s < stall; s++) begin
            @(posedge clock_i); #1;
            check({tag, " stall valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, " stall rdata"}, bus.resp_rdata, e.rdata);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock_i); #1;
        bus.resp_ready = 1'b0;
        check({tag, " done"}, 32'(bus.resp_valid), 32'd0);
    endtask

    vec_t vt[$];

    task automatic add(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] base, input logic [31:0] off, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rdata, input logic [31:0] addr,
                       input logic [3:0] wen, input logic [1:0] ren, input logic [31:0] wd_exp);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.base = base; v.off = off; v.wdata = wdata;
        v.e = '{err: err, rdata: rdata, addr: addr, wen: wen, ren: ren, wdata: wd_exp};
        vt.push_back(v);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] hold;
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_base = 0;
        bus.req_offset = 0; bus.req_wdata = 0; bus.req_rd = 0; bus.resp_ready = 0;

        //            name        we f3     base          off           wdata         err rdata         addr wen ren wdata
        add("sw_10_4",   1, F3_W,  32'h10,       32'h4,        32'hDEADBEEF, 0, 32'h0,        5,  15, 0, 32'hDEADBEEF);
        add("lw_14",     0, F3_W,  32'h14,       32'h0,        32'h0,        0, 32'hDEADBEEF, 5,  0,  3, 32'h0);
        add("lb_17",     0, F3_B,  32'h17,       32'h0,        32'h0,        0, 32'hFFFFFFDE, 5,  0,  3, 32'h0);
        add("lbu_17",    0, F3_BU, 32'h17,       32'h0,        32'h0,        0, 32'h000000DE, 5,  0,  3, 32'h0);
        add("lh_14",     0, F3_H,  32'h14,       32'h0,        32'h0,        0, 32'hFFFFBEEF, 5,  0,  3, 32'h0);
        add("sb_21",     1, F3_B,  32'h20,       32'h1,        32'h123456AB, 0, 32'h0,        8,  2,  0, 32'h000000AB);
        add("lbu_21",    0, F3_BU, 32'h21,       32'h0,        32'h0,        0, 32'h000000AB, 8,  0,  3, 32'h0);
        add("lw_100",    0, F3_W,  32'h100,      32'h0,        32'h0,        1, 32'h0,        0,  0,  0, 32'h0);
        add("lw_102",    0, F3_W,  32'h100,      32'h2,        32'h0,        1, 32'h0,        0,  0,  0, 32'h0);
        add("lw_wrap",   0, F3_W,  32'hFFFFFFF8, 32'h1C,       32'h0,        0, 32'hDEADBEEF, 5,  0,  3, 32'h0);
        add("lhu_16",    0, F3_HU, 32'h18,       32'hFFFFFFFE, 32'h0,        0, 32'h0000DEAD, 5,  0,  3, 32'h0);
        add("sh_22",     1, F3_H,  32'h22,       32'h0,        32'hCAFEF00D, 0, 32'h0,        8,  7,  0, 32'h0000F00D);
        add("lw_20",     0, F3_W,  32'h20,       32'h0,        32'h0,        0, 32'hF00DAB00, 8,  0,  3, 32'h0);
        add("ld_f3_011", 0, 3'b011,32'h20,       32'h0,        32'h0,        1, 32'h0,        0,  0,  0, 32'h0);
        add("st_f3_100", 1, F3_BU, 32'h20,       32'h0,        32'h55,       1, 32'h0,        0,  0,  0, 32'h0);
        add("lb_ff",     0, F3_B,  32'hFF,       32'h0,        32'h0,        0, 32'h0,        63, 0,  3, 32'h0);
        add("sw_101",    1, F3_W,  32'h101,      32'h0,        32'h1,        1, 32'h0,        0,  0,  0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        add("lw_16_mis", 0, F3_W,  32'h16,       32'h0,        32'h0,        1, 32'h0,        0,  0,  0, 32'h0);
        add("lh_15_mis", 0, F3_H,  32'h15,       32'h0,        32'h0,        1, 32'h0,        0,  0,  0, 32'h0);
`else
        add("lw_16_aln", 0, F3_W,  32'h16,       32'h0,        32'h0,        0, 32'hDEADBEEF, 5,  0,  3, 32'h0);
        add("lh_15_aln", 0, F3_H,  32'h15,       32'h0,        32'h0,        0, 32'hFFFFBEEF, 5,  0,  3, 32'h0);
`endif

        // Reset state
        #1;
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst mem_wr_enable", 32'(bus.mem_wr_enable), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        repeat (2) @(posedge clock_i);
        @(negedge clock_i) reset_n_i = 1'b1;
        #1 check("post-rst req_ready", 32'(bus.req_ready), 32'd1);

        foreach (vt[i]) begin
            e = model(vt[i].we, vt[i].f3, vt[i].base + vt[i].off, vt[i].wdata);
            run(vt[i].we, vt[i].f3, vt[i].base, vt[i].off, vt[i].wdata, 5'(i), vt[i].e, vt[i].name, 0);
        end

        // Response stall with a new request pending: nothing accepted, response stable.
        @(negedge clock_i);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W;
        bus.req_base = 32'h14; bus.req_offset = 0; bus.req_rd = 5'd9;
        @(posedge clock_i); #1;
        @(posedge clock_i); #1;
        hold = bus.resp_rdata;
        check("stall first rdata", hold, 32'hDEADBEEF);
        for (int s = 0; s < 5; s++) begin
            @(posedge clock_i); #1;
            check("stall valid", 32'(bus.resp_valid), 32'd1);
            check("stall req_ready", 32'(bus.req_ready), 32'd0);
            check("stall rdata", bus.resp_rdata, 32'hDEADBEEF);
            check("stall rd", 32'(bus.resp_rd), 32'd9);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock_i); #1;
        bus.resp_ready = 1'b0;
        check("handshake no accept", 32'(bus.req_ready), 32'd1);
        check("handshake valid low", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 1'b0;

        // Reset pulsed during the ACCESS cycle of a store: nothing is written.
        @(negedge clock_i);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
        bus.req_base = 32'h30; bus.req_offset = 0; bus.req_wdata = 32'h55667788;
        @(posedge clock_i); #1;
        bus.req_valid = 1'b0;
        check("rst-mid strobe", 32'(bus.mem_wr_enable), 32'hF);
        #2 reset_n_i = 1'b0;
        #1;
        check("rst-mid wr_enable", 32'(bus.mem_wr_enable), 32'd0);
        check("rst-mid mem_addr", bus.mem_addr, 32'd0);
        check("rst-mid wr_data", bus.mem_wr_data, 32'd0);
        check("rst-mid resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clock_i);
        @(negedge clock_i) reset_n_i = 1'b1;
        #1;
        check("rst-mid req_ready", 32'(bus.req_ready), 32'd1);
        check("rst-mid mem", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'd0);
        e = model(1'b0, F3_W, 32'h30, 32'h0);
        run(1'b0, F3_W, 32'h30, 32'h0, 32'h0, 5'd3, e, "lw_30_after_rst", 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] base, off, wd;
            logic [4:0]  rd;
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            base = 32'($urandom_range(0, 32'h11F));
            off  = 32'(int'($urandom_range(0, 15)) - 8);
            wd   = $urandom;
            rd   = 5'($urandom_range(0, 31));
            e = model(we, f3, base + off, wd);
            run(we, f3, base, off, wd, rd, e, "rand", int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
